// File: rtl/seg_pkg.sv
// Shared constants and digit-extraction helper for the 7-segment scan path.
// Pure definitions: no latency, no flow control.
package seg_pkg;

  localparam logic [3:0] BCD_BLANK  = 4'hF;
  localparam int         BCD_W      = 4;
  localparam int         MAX_DIGITS = 8;
  localparam int         VEC_W      = BCD_W * MAX_DIGITS;

  // Callers zero-extend their packed value to VEC_W before passing it in.
  function automatic logic [BCD_W-1:0] bcd_digit(input logic [VEC_W-1:0] vec, input int idx);
    return vec[idx*BCD_W +: BCD_W];
  endfunction

endpackage

// File: rtl/seg_lzb_mask.sv
// Leading-zero blank mask: bit d set when digits NUM_DIGITS-1..d are all zero (d > 0).
// Combinational, zero latency, no flow control.
module seg_lzb_mask
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int LZ_BLANK   = 1
) (
  input  logic [BCD_W*NUM_DIGITS-1:0] i_bcd,
  output logic [NUM_DIGITS-1:0]       o_mask
);

  logic w_run_zero;

  // Digit 0 is never masked so an all-zero value still shows a single "0".
  always_comb begin
    o_mask     = '0;
    w_run_zero = 1'b1;
    for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
      w_run_zero = w_run_zero && (bcd_digit(VEC_W'(i_bcd), d) == 4'd0);
      o_mask[d]  = (LZ_BLANK != 0) && w_run_zero;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver with blank interval and frame-aligned, tear-free value updates.
// Outputs registered (1 clk); LOAD always accepted, applied at the next frame boundary with a 1-cycle ACK.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int BLANK_CYC  = 16,
  parameter int LZ_BLANK   = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [BCD_W*NUM_DIGITS-1:0] i_digits_in,
  input  logic                        i_load,
  output logic                        o_load_ack,
  output logic [BCD_W-1:0]            o_bcd_out,
  output logic [NUM_DIGITS-1:0]       o_dig_en,
  output logic                        o_frame_start
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYC);
  localparam logic [IW-1:0] I_LAST  = IW'(NUM_DIGITS - 1);

  // r_p/r_i name the position whose outputs are registered at the next edge.
  logic [PW-1:0]               r_p;
  logic [IW-1:0]               r_i;
  logic [BCD_W*NUM_DIGITS-1:0] r_shadow;
  logic [BCD_W*NUM_DIGITS-1:0] r_active;
  logic                        r_pending;

  logic [NUM_DIGITS-1:0] w_lz_mask;
  logic                  w_boundary;
  logic                  w_visible;
  logic [BCD_W-1:0]      w_digit;

  seg_lzb_mask #(
    .NUM_DIGITS (NUM_DIGITS),
    .LZ_BLANK   (LZ_BLANK)
  ) u_lzb (
    .i_bcd  (r_active),
    .o_mask (w_lz_mask)
  );

  assign w_boundary = (r_p == '0) && (r_i == '0);
  assign w_visible  = (r_p >= P_BLANK);
  assign w_digit    = w_lz_mask[r_i] ? BCD_BLANK : bcd_digit(VEC_W'(r_active), int'(r_i));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_p <= '0;
      r_i <= '0;
    end else if (r_p == P_LAST) begin
      r_p <= '0;
      r_i <= (r_i == I_LAST) ? '0 : r_i + 1'b1;
    end else begin
      r_p <= r_p + 1'b1;
    end
  end

  // A LOAD coinciding with the boundary bypasses the shadow and wins over any pending value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shadow   <= '0;
      r_active   <= '0;
      r_pending  <= 1'b0;
      o_load_ack <= 1'b0;
    end else begin
      o_load_ack <= 1'b0;
      if (w_boundary) begin
        if (i_load) begin
          r_active <= i_digits_in;
        end else if (r_pending) begin
          r_active <= r_shadow;
        end
        o_load_ack <= i_load || r_pending;
        r_pending  <= 1'b0;
      end else if (i_load) begin
        r_shadow  <= i_digits_in;
        r_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_bcd_out     <= BCD_BLANK;
      o_dig_en      <= '0;
      o_frame_start <= 1'b0;
    end else begin
      o_frame_start <= w_boundary;
      o_dig_en      <= w_visible ? (NUM_DIGITS'(1) << r_i) : '0;
      o_bcd_out     <= w_visible ? w_digit : BCD_BLANK;
    end
  end

endmodule
